// File: rtl/rftfa_serial_adder.sv
// Bit-serial adder sequencer driving a 4-line reversible full-adder stage.
// One bit slice per cycle; collects sum, carry-out and garbage lines for later uncompute.
module rftfa_serial_adder #(
  parameter int WIDTH    = 8,
  parameter int SUM_BIT  = 2,
  parameter int COUT_BIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cin,
  output logic [3:0]           fa_in,
  input  logic [3:0]           fa_out,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     sum,
  output logic                 cout,
  output logic [2*WIDTH-1:0]   garb
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Returns the which-th (0 or 1) stage line that is neither the sum nor the carry line.
  function automatic int garb_idx(input int s, input int c, input int which);
    int n;
    n = 0;
    garb_idx = 0;
    for (int i = 0; i < 4; i++) begin
      if (i != s && i != c) begin
        if (n == which) begin
          garb_idx = i;
        end
        n = n + 1;
      end
    end
  endfunction

  localparam int G0 = garb_idx(SUM_BIT, COUT_BIT, 0);
  localparam int G1 = garb_idx(SUM_BIT, COUT_BIT, 1);

  if (SUM_BIT == COUT_BIT || SUM_BIT < 0 || SUM_BIT > 3 ||
      COUT_BIT < 0 || COUT_BIT > 3 || WIDTH < 2) begin : g_param_check
    $error("rftfa_serial_adder: invalid WIDTH/SUM_BIT/COUT_BIT");
  end

  logic [1:0]         state_q,   state_d;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic [WIDTH-1:0]   a_sh_q,    a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,    b_sh_d;
  logic               carry_q,   carry_d;
  logic [WIDTH-1:0]   sum_sh_q,  sum_sh_d;
  logic [2*WIDTH-1:0] garb_sh_q, garb_sh_d;
  logic [WIDTH-1:0]   sum_q,     sum_d;
  logic               cout_q,    cout_d;
  logic [2*WIDTH-1:0] garb_q,    garb_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;

  // Next-state logic and stage drive; the final slice is folded straight into the result registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    carry_d   = carry_q;
    sum_sh_d  = sum_sh_q;
    garb_sh_d = garb_sh_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    garb_d    = garb_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    fa_in     = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d    = a;
          b_sh_d    = b;
          carry_d   = cin;
          cnt_d     = '0;
          sum_sh_d  = '0;
          garb_sh_d = '0;
          busy_d    = 1'b1;
          state_d   = ST_RUN;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_RUN: begin
        fa_in     = {1'b0, carry_q, b_sh_q[0], a_sh_q[0]};
        sum_sh_d  = {fa_out[SUM_BIT], sum_sh_q[WIDTH-1:1]};
        garb_sh_d = {fa_out[G1], fa_out[G0], garb_sh_q[2*WIDTH-1:2]};
        carry_d   = fa_out[COUT_BIT];
        a_sh_d    = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d    = {1'b0, b_sh_q[WIDTH-1:1]};
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = sum_sh_d;
          cout_d  = carry_d;
          garb_d  = garb_sh_d;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      carry_q   <= 1'b0;
      sum_sh_q  <= '0;
      garb_sh_q <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      garb_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      carry_q   <= carry_d;
      sum_sh_q  <= sum_sh_d;
      garb_sh_q <= garb_sh_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      garb_q    <= garb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign garb = garb_q;

endmodule

// File: tb/tb_rftfa_serial_adder.sv
// Scoreboard bench for rftfa_serial_adder with an attached reversible full-adder stage
// (lines out: [0]=a, [1]=a^b, [2]=sum, [3]=carry).
module tb_rftfa_serial_adder;
  localparam int WIDTH = 8;
  localparam int NRAND = 1000;

  typedef struct {
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [2*WIDTH-1:0] garb;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [WIDTH-1:0]   a = '0;
  logic [WIDTH-1:0]   b = '0;
  logic               cin = 1'b0;
  logic [3:0]         fa_in;
  logic [3:0]         fa_out;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [2*WIDTH-1:0] garb;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   run_k = -1;
  int   free_at = 0;
  int   n_acc = 0;
  int   fa3_bad = 0;
  exp_t sb[$];
  exp_t e;
  exp_t last;
  bit   eb, ed;

  rftfa_serial_adder #(.WIDTH(WIDTH), .SUM_BIT(2), .COUT_BIT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .fa_in(fa_in), .fa_out(fa_out), .busy(busy), .done(done),
    .sum(sum), .cout(cout), .garb(garb)
  );

  // Reversible full-adder stage: A, A^B, A^B^C^D, (A^B)C ^ AB ^ D.
  assign fa_out[0] = fa_in[0];
  assign fa_out[1] = fa_in[0] ^ fa_in[1];
  assign fa_out[2] = fa_in[0] ^ fa_in[1] ^ fa_in[2] ^ fa_in[3];
  assign fa_out[3] = ((fa_in[0] ^ fa_in[1]) & fa_in[2]) ^ (fa_in[0] & fa_in[1]) ^ fa_in[3];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 20000", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv);
    exp_t m;
    logic [WIDTH:0] t;
    t = {1'b0, av} + {1'b0, bv} + (WIDTH+1)'(cv);
    m.sum  = t[WIDTH-1:0];
    m.cout = t[WIDTH];
    for (int i = 0; i < WIDTH; i++) begin
      m.garb[2*i]   = av[i];
      m.garb[2*i+1] = av[i] ^ bv[i];
    end
    return m;
  endfunction

  // One cycle of stimulus; the bench predicts acceptance from its own timing model.
  task automatic drive(input bit s, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input bit cv);
    @(negedge clk);
    start = s;
    a = av;
    b = bv;
    cin = cv;
    if (s && (cyc + 1 >= free_at)) begin
      sb.push_back(model(av, bv, cv));
      run_k   = cyc + 1;
      free_at = cyc + 1 + WIDTH + 2;
      n_acc++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_sum"}, 64'(sum), 64'(0));
    chk({tag, "_cout"}, 64'(cout), 64'(0));
    chk({tag, "_garb"}, 64'(garb), 64'(0));
    chk({tag, "_fa_in"}, 64'(fa_in), 64'(0));
  endtask

  // Monitor: protocol timing, result pops on done, and hold of results in between.
  always @(negedge clk) begin
    if (!rst) begin
      eb = (run_k >= 0) && (cyc >= run_k) && (cyc < run_k + WIDTH);
      ed = (run_k >= 0) && (cyc == run_k + WIDTH);
      chk("busy", 64'(busy), 64'(eb));
      chk("done", 64'(done), 64'(ed));
      if (fa_in[3] !== 1'b0) fa3_bad++;
      if (!eb) chk("fa_in_quiet", 64'(fa_in), 64'(0));
      if (done) begin
        chk("sb_depth_on_done", 64'(sb.size()), 64'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sum", 64'(sum), 64'(e.sum));
          chk("cout", 64'(cout), 64'(e.cout));
          chk("garb", 64'(garb), 64'(e.garb));
          last = e;
        end
      end else begin
        chk("sum_hold", 64'(sum), 64'(last.sum));
        chk("cout_hold", 64'(cout), 64'(last.cout));
        chk("garb_hold", 64'(garb), 64'(last.garb));
      end
    end
  end

  initial begin
    last.sum  = '0;
    last.cout = 1'b0;
    last.garb = '0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;
    idle(2);

    drive(1'b1, 8'h5A, 8'h3C, 1'b0);
    idle(12);
    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    idle(12);
    drive(1'b1, 8'hFF, 8'hFF, 1'b1);
    idle(12);

    // Start pulsed through RUN and DONE: only the first request may be taken.
    for (int i = 0; i < WIDTH + 2; i++)
      drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    idle(12);

    // Abort in the 4th RUN cycle.
    drive(1'b1, 8'hA5, 8'h5A, 1'b1);
    idle(3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero_outputs("abort");
    sb.delete();
    run_k     = -1;
    free_at   = 0;
    last.sum  = '0;
    last.cout = 1'b0;
    last.garb = '0;
    @(negedge clk);
    rst = 1'b0;
    idle(12);

    drive(1'b1, 8'h01, 8'h01, 1'b0);
    idle(12);

    // Start held high with fresh operands every cycle.
    begin
      int target;
      target = n_acc + NRAND;
      for (int it = 0; it < NRAND * (WIDTH + 2) + 20 && n_acc < target; it++)
        drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
      chk("random_accept_count", 64'(n_acc), 64'(target));
    end
    idle(15);

    chk("sb_empty_at_end", 64'(sb.size()), 64'(0));
    chk("fa_in3_always_zero", 64'(fa3_bad), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
